// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes, MDU state encoding and operand width.
// The DIV state exists only when MUL_DIV_SEQ_DIV_EN is defined.
package mips_pkg;

    localparam int W = 32;

    // ALU funct codes
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_JR    = 6'b001000;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_ADDU  = 6'b100001;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_SUBU  = 6'b100011;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    // MDU funct codes
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
`ifdef MUL_DIV_SEQ_DIV_EN
        S_DIV   = 3'd2,
`endif
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } mdu_state_e;

    function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
        return (is_signed && v[W-1]) ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mdu_step.sv
// One iteration of the sequential MDU: shift-add multiply step, and (with
// MUL_DIV_SEQ_DIV_EN) one restoring-divide step.
module mdu_step
    import mips_pkg::*;
(
`ifdef MUL_DIV_SEQ_DIV_EN
    input  logic         is_div,
`endif
    input  logic [W-1:0] r_in,
    input  logic [W-1:0] q_in,
    input  logic [W-1:0] b_in,
    output logic [W-1:0] r_out,
    output logic [W-1:0] q_out
);

    logic [W:0] sum;
`ifdef MUL_DIV_SEQ_DIV_EN
    logic [W:0] shifted;
    logic [W:0] diff;
`endif

    always_comb begin
        // Multiply: {r,q} holds {partial product, unconsumed multiplier bits}
        sum   = {1'b0, r_in} + (q_in[0] ? {1'b0, b_in} : '0);
        r_out = sum[W:1];
        q_out = {sum[0], q_in[W-1:1]};
`ifdef MUL_DIV_SEQ_DIV_EN
        // r < b always holds, so shifted < 2b and diff[W] is the borrow
        shifted = {r_in, q_in[W-1]};
        diff    = shifted - {1'b0, b_in};
        if (is_div) begin
            r_out = diff[W] ? shifted[W-1:0] : diff[W-1:0];
            q_out = {q_in[W-2:0], ~diff[W]};
        end
`endif
    end

endmodule

// File: rtl/mul_div_seq.sv
// Sequential MIPS multiply/divide unit with HI/LO registers, 34-cycle latency.
// Divide support is compiled in only when MUL_DIV_SEQ_DIV_EN is defined.
module mul_div_seq
    import mips_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [5:0]   funct,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         div_by_zero
);

    mdu_state_e   state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [W-1:0] r_q, r_d;
    logic [W-1:0] q_q, q_d;
    logic [W-1:0] b_q, b_d;
    logic         neg_q, neg_d;
    logic [W-1:0] hi_q, hi_d;
    logic [W-1:0] lo_q, lo_d;
    logic [W-1:0] step_r, step_q;
    logic [2*W-1:0] prod;
    logic         sgn;
`ifdef MUL_DIV_SEQ_DIV_EN
    logic         rneg_q, rneg_d;
    logic         div_op_q, div_op_d;
    logic         dz_q, dz_d;
`endif

    mdu_step u_step (
`ifdef MUL_DIV_SEQ_DIV_EN
        .is_div (state_q == S_DIV),
`endif
        .r_in   (r_q),
        .q_in   (q_q),
        .b_in   (b_q),
        .r_out  (step_r),
        .q_out  (step_q)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        r_d      = r_q;
        q_d      = q_q;
        b_d      = b_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        prod     = '0;
        sgn      = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
`ifdef MUL_DIV_SEQ_DIV_EN
        rneg_d   = rneg_q;
        div_op_d = div_op_q;
        dz_d     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (funct)
                        F_MTHI: hi_d = A;
                        F_MTLO: lo_d = A;
                        F_MULT, F_MULTU: begin
                            sgn     = (funct == F_MULT);
                            state_d = S_MUL;
                            cnt_d   = '0;
                            r_d     = '0;
                            q_d     = magnitude(B, sgn);
                            b_d     = magnitude(A, sgn);
                            neg_d   = sgn & (A[W-1] ^ B[W-1]);
`ifdef MUL_DIV_SEQ_DIV_EN
                            rneg_d   = 1'b0;
                            div_op_d = 1'b0;
`endif
                        end
`ifdef MUL_DIV_SEQ_DIV_EN
                        F_DIV, F_DIVU: begin
                            sgn = (funct == F_DIV);
                            if (B == '0) begin
                                state_d = S_DONE;
                                dz_d    = 1'b1;
                            end else begin
                                state_d  = S_DIV;
                                cnt_d    = '0;
                                r_d      = '0;
                                q_d      = magnitude(A, sgn);
                                b_d      = magnitude(B, sgn);
                                neg_d    = sgn & (A[W-1] ^ B[W-1]);
                                rneg_d   = sgn & A[W-1];
                                div_op_d = 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
`ifdef MUL_DIV_SEQ_DIV_EN
            S_MUL, S_DIV: begin
`else
            S_MUL: begin
`endif
                busy  = 1'b1;
                r_d   = step_r;
                q_d   = step_q;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == '1) state_d = S_FIXUP;
            end
            S_FIXUP: begin
                busy    = 1'b1;
                state_d = S_DONE;
`ifdef MUL_DIV_SEQ_DIV_EN
                if (div_op_q) begin
                    lo_d = neg_q  ? (~q_q + 1'b1) : q_q;
                    hi_d = rneg_q ? (~r_q + 1'b1) : r_q;
                end else begin
`endif
                    prod = {r_q, q_q};
                    if (neg_q) prod = ~prod + 1'b1;
                    hi_d = prod[2*W-1:W];
                    lo_d = prod[W-1:0];
`ifdef MUL_DIV_SEQ_DIV_EN
                end
`endif
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            r_q      <= '0;
            q_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef MUL_DIV_SEQ_DIV_EN
            rneg_q   <= 1'b0;
            div_op_q <= 1'b0;
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            r_q      <= r_d;
            q_q      <= q_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef MUL_DIV_SEQ_DIV_EN
            rneg_q   <= rneg_d;
            div_op_q <= div_op_d;
            dz_q     <= dz_d;
`endif
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
`ifdef MUL_DIV_SEQ_DIV_EN
    assign div_by_zero = dz_q & (state_q == S_DONE);
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mul_div_seq.sv
// Directed self-checking bench for mul_div_seq; divide vectors run only when
// MUL_DIV_SEQ_DIV_EN is defined, otherwise DIV must be ignored.
module tb_mul_div_seq;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  funct = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int n_vec = 0;
    int n_err = 0;

    mul_div_seq #(.W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .funct       (funct),
        .A           (a),
        .B           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operands are scrambled after acceptance so the op in flight must use latched copies
    task automatic issue(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
        start = 1'b1;
        funct = f;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input int first, output int lat, output int busy_cycles);
        lat = first;
        busy_cycles = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (busy === 1'b1) busy_cycles++;
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [5:0] f,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int exp_lat, input logic exp_dz);
        int lat, bc;
        issue(f, av, bv);
        wait_done(1, lat, bc);
        chk({tag, ".lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, ".busy_cycles"}, 64'(bc), 64'(exp_lat - 1));
        chk({tag, ".hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, ".lo"}, 64'(lo), 64'(exp_lo));
        chk({tag, ".dbz"}, 64'(div_by_zero), 64'(exp_dz));
        tick();
        chk({tag, ".done_clr"}, 64'(done), 64'd0);
        chk({tag, ".hi_hold"}, 64'(hi), 64'(exp_hi));
        chk({tag, ".lo_hold"}, 64'(lo), 64'(exp_lo));
    endtask

    initial begin
        int lat, bc, pulses;

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.dbz", 64'(div_by_zero), 64'd0);
        chk("rst.hi", 64'(hi), 64'd0);
        chk("rst.lo", 64'(lo), 64'd0);
        rst_n = 1'b1;
        tick();

        // MTLO / MTHI write in one cycle without going busy
        issue(F_MTLO, 32'h12345678, 32'h0);
        chk("mtlo.lo", 64'(lo), 64'h12345678);
        chk("mtlo.busy", 64'(busy), 64'd0);
        chk("mtlo.done", 64'(done), 64'd0);
        issue(F_MTHI, 32'hCAFEF00D, 32'h0);
        chk("mthi.hi", 64'(hi), 64'hCAFEF00D);
        chk("mthi.lo", 64'(lo), 64'h12345678);

        issue(F_ADD, 32'h11111111, 32'h22222222);
        chk("unlisted.busy", 64'(busy), 64'd0);
        tick();
        chk("unlisted.done", 64'(done), 64'd0);
        chk("unlisted.hi", 64'(hi), 64'hCAFEF00D);
        chk("unlisted.lo", 64'(lo), 64'h12345678);

        run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 1'b0);
        run_op("mult_neg", F_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 34, 1'b0);
        run_op("mult_minsq", F_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 34, 1'b0);
        run_op("mult_zero", F_MULT, 32'h00000000, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 34, 1'b0);
        run_op("mult_m1sq", F_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 34, 1'b0);

        // MTHI during a multiply must be ignored
        issue(F_MULT, 32'h00001234, 32'hFFFFFFFE);
        tick(); tick(); tick();
        start = 1'b1;
        funct = F_MTHI;
        a     = 32'hDEADBEEF;
        tick();
        start = 1'b0;
        wait_done(5, lat, bc);
        chk("mthi_busy.lat", 64'(lat), 64'd34);
        chk("mthi_busy.hi", 64'(hi), 64'hFFFFFFFF);
        chk("mthi_busy.lo", 64'(lo), 64'hFFFFDB98);
        tick();

`ifdef MUL_DIV_SEQ_DIV_EN
        run_op("div_neg", F_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 1'b0);
        run_op("divu_zero", F_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1, 1'b1);
        run_op("div_ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 1'b0);
        run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 34, 1'b0);
        run_op("div_7_m2", F_DIV, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 34, 1'b0);
`else
        issue(F_DIV, 32'hFFFFFFF9, 32'd2);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) pulses++;
            tick();
        end
        chk("nodiv.activity", 64'(pulses), 64'd0);
        chk("nodiv.hi", 64'(hi), 64'hFFFFFFFF);
        chk("nodiv.lo", 64'(lo), 64'hFFFFDB98);
`endif

        // Reset mid-multiply clears immediately and suppresses done
        issue(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (8) tick();
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort.busy", 64'(busy), 64'd0);
        chk("abort.done", 64'(done), 64'd0);
        chk("abort.hi", 64'(hi), 64'd0);
        chk("abort.lo", 64'(lo), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1 || busy === 1'b1) pulses++;
            tick();
        end
        chk("abort.no_done", 64'(pulses), 64'd0);
        chk("abort.hi_after", 64'(hi), 64'd0);
        run_op("post_rst", F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 34, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
